tx_response_scheduler: RTL and testbench

//  Queues response frames (error bytes, read-data words) from the command controller and

---
 rtl/tx_response_scheduler.sv | 130 +++++++++++++
 tb/tb_tx_response_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_response_scheduler.sv
// Queues response frames and feeds them one at a time to word_to_byte_tx over enable/done.
// Latency: push into empty idle queue -> enable one cycle later; one-cycle enable gap between frames.
// Backpressure: none upstream; a push into a full queue is dropped and flagged on o_drop. TX_SCHED_DROP_COUNT_EN adds o_drop_count.
module tx_response_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_mode_select,
    input  logic [31:0]   i_word,
    input  logic [7:0]    i_byte,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count,
    output logic          o_drop,
    output logic          o_busy,
    output logic          o_wtb_enable,
    output logic          o_wtb_mode_select,
    output logic [31:0]   o_wtb_word,
    output logic [7:0]    o_wtb_byte,
    input  logic          i_wtb_done
`ifdef TX_SCHED_DROP_COUNT_EN
    ,
    output logic [7:0]    o_drop_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t        state_q, state_d;
    logic [32:0]   mem [DEPTH];
    logic [32:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q, count_d;
    logic          pop, push_ok, push_rej;

    assign head     = mem[rd_ptr];
    assign o_count  = count_q;
    assign o_busy   = (state_q != IDLE);
    // A pop on the same edge frees a slot, so a push into a full queue is still accepted.
    assign push_ok  = i_push && (!o_full || pop);
    assign push_rej = i_push && !push_ok;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!o_empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (i_wtb_done) state_d = GAP;
            end
            GAP: begin
                if (!o_empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + CNT_ONE;
        else if (!push_ok && pop) count_d = count_q - CNT_ONE;
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= {i_mode_select, i_mode_select ? i_word : {24'h0, i_byte}};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count_q           <= '0;
            o_full            <= 1'b0;
            o_empty           <= 1'b1;
            o_drop            <= 1'b0;
            o_wtb_enable      <= 1'b0;
            o_wtb_mode_select <= 1'b0;
            o_wtb_word        <= '0;
            o_wtb_byte        <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            o_full       <= (count_d == CNT_FULL);
            o_empty      <= (count_d == '0);
            o_drop       <= push_rej;
            o_wtb_enable <= (state_d == SEND);
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr            <= rd_ptr + PTR_ONE;
                o_wtb_mode_select <= head[32];
                o_wtb_word        <= head[31:0];
                o_wtb_byte        <= head[7:0];
            end
        end
    end

`ifdef TX_SCHED_DROP_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_drop_count <= 8'h00;
        end else if (push_rej && (o_drop_count != 8'hFF)) begin
            o_drop_count <= o_drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_response_scheduler.sv
// Directed bench for tx_response_scheduler: one task per scenario, hand-computed expectations.
module tb_tx_response_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_push = 1'b0;
    logic        i_mode_select = 1'b0;
    logic [31:0] i_word = '0;
    logic [7:0]  i_byte = '0;
    logic        o_full, o_empty, o_drop, o_busy;
    logic [2:0]  o_count;
    logic        o_wtb_enable, o_wtb_mode_select;
    logic [31:0] o_wtb_word;
    logic [7:0]  o_wtb_byte;
    logic        i_wtb_done = 1'b0;
`ifdef TX_SCHED_DROP_COUNT_EN
    logic [7:0]  o_drop_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_bytes [4];

    tx_response_scheduler #(.DEPTH(4), .AW(2)) dut (
        .clock(clock), .reset(reset),
        .i_push(i_push), .i_mode_select(i_mode_select), .i_word(i_word), .i_byte(i_byte),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_drop(o_drop), .o_busy(o_busy),
        .o_wtb_enable(o_wtb_enable), .o_wtb_mode_select(o_wtb_mode_select),
        .o_wtb_word(o_wtb_word), .o_wtb_byte(o_wtb_byte), .i_wtb_done(i_wtb_done)
`ifdef TX_SCHED_DROP_COUNT_EN
        , .o_drop_count(o_drop_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", o_empty); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
        checks++; if ({o_full, o_drop, o_busy, o_wtb_enable, o_wtb_mode_select} !== 5'b0)
            begin errors++; $display("FAIL reset_flags got %b want 00000", {o_full, o_drop, o_busy, o_wtb_enable, o_wtb_mode_select}); end
        checks++; if ({o_wtb_word, o_wtb_byte} !== 40'h0) begin errors++; $display("FAIL reset_data got %h want 0", {o_wtb_word, o_wtb_byte}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_byte();
        i_push = 1'b1; i_mode_select = 1'b0; i_byte = 8'h02;
        step();
        i_push = 1'b0;
        checks++; if (o_wtb_enable !== 1'b0) begin errors++; $display("FAIL single_early_en got %b want 0", o_wtb_enable); end
        checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", o_count); end
        step();
        checks++; if (o_wtb_enable !== 1'b1) begin errors++; $display("FAIL single_en got %b want 1", o_wtb_enable); end
        checks++; if ({o_wtb_mode_select, o_wtb_byte, o_wtb_word} !== {1'b0, 8'h02, 32'h02})
            begin errors++; $display("FAIL single_data got %b %h %h want 0 02 00000002", o_wtb_mode_select, o_wtb_byte, o_wtb_word); end
        step();
        step();
        checks++; if ({o_wtb_enable, o_busy} !== 2'b11) begin errors++; $display("FAIL single_hold got %b want 11", {o_wtb_enable, o_busy}); end
        i_wtb_done = 1'b1;
        step();
        i_wtb_done = 1'b0;
        checks++; if ({o_wtb_enable, o_busy} !== 2'b01) begin errors++; $display("FAIL single_gap got %b want 01", {o_wtb_enable, o_busy}); end
        step();
        checks++; if ({o_wtb_enable, o_busy, o_empty} !== 3'b001) begin errors++; $display("FAIL single_idle got %b want 001", {o_wtb_enable, o_busy, o_empty}); end
    endtask

    task automatic test_back_to_back();
        i_push = 1'b1; i_mode_select = 1'b1; i_word = 32'hDEADBEEF;
        step();
        i_mode_select = 1'b0; i_byte = 8'h01; i_word = 32'h0;
        step();
        i_push = 1'b0;
        checks++; if ({o_wtb_enable, o_wtb_mode_select, o_wtb_word} !== {2'b11, 32'hDEADBEEF})
            begin errors++; $display("FAIL b2b_first got %b %b %h want 1 1 deadbeef", o_wtb_enable, o_wtb_mode_select, o_wtb_word); end
        checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL b2b_count got %0d want 1", o_count); end
        step();
        i_wtb_done = 1'b1;
        step();
        i_wtb_done = 1'b0;
        checks++; if (o_wtb_enable !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b want 0", o_wtb_enable); end
        step();
        checks++; if ({o_wtb_enable, o_wtb_mode_select, o_wtb_byte} !== {2'b10, 8'h01})
            begin errors++; $display("FAIL b2b_second got %b %b %h want 1 0 01", o_wtb_enable, o_wtb_mode_select, o_wtb_byte); end
        i_wtb_done = 1'b1;
        step();
        i_wtb_done = 1'b0;
        step();
        checks++; if ({o_busy, o_empty, o_wtb_enable} !== 3'b010) begin errors++; $display("FAIL b2b_idle got %b want 010", {o_busy, o_empty, o_wtb_enable}); end
    endtask

    task automatic test_fill_and_full_pushpop();
        exp_bytes = '{8'h12, 8'h13, 8'h14, 8'h16};
        i_push = 1'b1; i_mode_select = 1'b0; i_byte = 8'h10;
        step();
        i_push = 1'b0;
        step();
        checks++; if ({o_wtb_enable, o_wtb_byte} !== {1'b1, 8'h10}) begin errors++; $display("FAIL fill_launch got %b %h want 1 10", o_wtb_enable, o_wtb_byte); end
        for (int i = 0; i < 5; i++) begin
            i_push = 1'b1; i_byte = 8'h11 + 8'(i);
            step();
        end
        i_push = 1'b0;
        checks++; if ({o_drop, o_full, o_count} !== {2'b11, 3'd4}) begin errors++; $display("FAIL fill_full got drop=%b full=%b count=%0d want 1 1 4", o_drop, o_full, o_count); end
        step();
        checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL fill_drop_pulse got %b want 0", o_drop); end
`ifdef TX_SCHED_DROP_COUNT_EN
        checks++; if (o_drop_count !== 8'd1) begin errors++; $display("FAIL fill_drop_count got %0d want 1", o_drop_count); end
`endif
        i_wtb_done = 1'b1;
        step();
        i_wtb_done = 1'b0;
        i_push = 1'b1; i_byte = 8'h16;
        step();
        i_push = 1'b0;
        checks++; if ({o_wtb_enable, o_wtb_byte} !== {1'b1, 8'h11}) begin errors++; $display("FAIL pushpop_launch got %b %h want 1 11", o_wtb_enable, o_wtb_byte); end
        checks++; if ({o_drop, o_full, o_count} !== {2'b01, 3'd4}) begin errors++; $display("FAIL pushpop_count got drop=%b full=%b count=%0d want 0 1 4", o_drop, o_full, o_count); end
        for (int i = 0; i < 4; i++) begin
            i_wtb_done = 1'b1;
            step();
            i_wtb_done = 1'b0;
            checks++; if (o_wtb_enable !== 1'b0) begin errors++; $display("FAIL drain_gap%0d got %b want 0", i, o_wtb_enable); end
            step();
            checks++; if ({o_wtb_enable, o_wtb_byte} !== {1'b1, exp_bytes[i]})
                begin errors++; $display("FAIL drain_order%0d got %b %h want 1 %h", i, o_wtb_enable, o_wtb_byte, exp_bytes[i]); end
        end
        i_wtb_done = 1'b1;
        step();
        i_wtb_done = 1'b0;
        step();
        checks++; if ({o_busy, o_empty, o_wtb_enable} !== 3'b010) begin errors++; $display("FAIL drain_idle got %b want 010", {o_busy, o_empty, o_wtb_enable}); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 4; i++) begin
            i_push = 1'b1; i_mode_select = 1'b0; i_byte = 8'h30 + 8'(i);
            step();
        end
        i_push = 1'b0;
        checks++; if ({o_wtb_enable, o_count} !== {1'b1, 3'd3}) begin errors++; $display("FAIL midrst_pre got %b %0d want 1 3", o_wtb_enable, o_count); end
        #1 reset = 1'b1;
        #1;
        checks++; if ({o_wtb_enable, o_empty, o_count} !== {2'b01, 3'd0}) begin errors++; $display("FAIL midrst_async got en=%b empty=%b count=%0d want 0 1 0", o_wtb_enable, o_empty, o_count); end
        step();
        step();
        reset = 1'b0;
        step();
        step();
        step();
        checks++; if ({o_wtb_enable, o_busy, o_empty} !== 3'b001) begin errors++; $display("FAIL midrst_after got %b want 001", {o_wtb_enable, o_busy, o_empty}); end
    endtask

    task automatic test_spurious_done();
        i_wtb_done = 1'b1;
        step();
        step();
        step();
        i_wtb_done = 1'b0;
        checks++; if ({o_wtb_enable, o_busy, o_empty, o_count} !== {3'b001, 3'd0})
            begin errors++; $display("FAIL spurious got en=%b busy=%b empty=%b count=%0d want 0 0 1 0", o_wtb_enable, o_busy, o_empty, o_count); end
    endtask

    task automatic test_drop_saturation();
        i_push = 1'b1; i_mode_select = 1'b0; i_byte = 8'h20;
        for (int i = 0; i < 306; i++) step();
        checks++; if ({o_drop, o_full, o_count} !== {2'b11, 3'd4}) begin errors++; $display("FAIL sat_state got drop=%b full=%b count=%0d want 1 1 4", o_drop, o_full, o_count); end
`ifdef TX_SCHED_DROP_COUNT_EN
        checks++; if (o_drop_count !== 8'hFF) begin errors++; $display("FAIL sat_count got %h want ff", o_drop_count); end
`endif
        i_push = 1'b0;
        step();
        checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL sat_drop_clear got %b want 0", o_drop); end
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef TX_SCHED_DROP_COUNT_EN
        checks++; if (o_drop_count !== 8'h00) begin errors++; $display("FAIL sat_count_reset got %h want 00", o_drop_count); end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fill_and_full_pushpop();
        test_reset_mid_frame();
        test_spurious_done();
        test_drop_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
